// File: rtl/skolem_chk_pkg.sv
// Shared types and arithmetic helpers for the Skolem witness checkers.
// Helpers work on values sign-extended to MAXW bits.
package skolem_chk_pkg;

    localparam int MAXW = 32;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        REPORT,
        DONE
    } state_t;

    // A sign-extended W-bit value shifted by W-1 or more is already
    // all sign bits, so clamping only matters at the container width.
    function automatic logic signed [MAXW-1:0] sra_sat(
        input logic signed [MAXW-1:0] x,
        input logic [MAXW-1:0]        s
    );
        logic signed [MAXW-1:0] r;
        if (s >= MAXW)
            r = x >>> (MAXW - 1);
        else
            r = x >>> s;
        return r;
    endfunction

    function automatic logic slt(
        input logic signed [MAXW-1:0] a,
        input logic signed [MAXW-1:0] b
    );
        return a < b;
    endfunction

endpackage

// File: rtl/skolem_pair_eval.sv
// Combinational bvslt/bvashr check of one (s, t, x) triple.
// Ports: s, t, x in; ic, sat, fail out.
module skolem_pair_eval
    import skolem_chk_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic [W-1:0] x,
    output logic         ic,
    output logic         sat,
    output logic         fail
);

    logic [MAXW-1:0]        sz;
    logic signed [MAXW-1:0] mine;
    logic signed [MAXW-1:0] te;
    logic signed [MAXW-1:0] xe;

    assign sz   = MAXW'(s);
    assign mine = {{(MAXW-W+1){1'b1}}, {(W-1){1'b0}}};
    assign te   = {{(MAXW-W){t[W-1]}}, t};
    assign xe   = {{(MAXW-W){x[W-1]}}, x};

    assign ic   = slt(sra_sat(mine, sz), te);
    assign sat  = slt(sra_sat(xe, sz), te);
    assign fail = ic && !sat;

endmodule

// File: rtl/skolem_sweep_checker.sv
// Sweeps all (s,t) pairs through an external Skolem candidate and
// checks each witness. Ports: start/busy/done control, cand_* to the
// candidate, fail_* valid/ready stream, ic/fail counters, first_fail.
module skolem_sweep_checker
    import skolem_chk_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 2 * W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     cand_s,
    output logic [W-1:0]     cand_t,
    input  logic [W-1:0]     cand_x,
    output logic             fail_valid,
    input  logic             fail_ready,
    output logic [W-1:0]     fail_s,
    output logic [W-1:0]     fail_t,
    output logic [W-1:0]     fail_x,
    output logic [CNT_W-1:0] ic_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [3*W-1:0]   first_fail,
    output logic             first_fail_vld
);

    state_t         state;
    logic [2*W-1:0] idx;
    logic           ic;
    logic           sat;
    logic           fail;
    logic           last;

    skolem_pair_eval #(.W(W)) u_eval (
        .s    (cand_s),
        .t    (cand_t),
        .x    (cand_x),
        .ic   (ic),
        .sat  (sat),
        .fail (fail)
    );

    assign last = (idx == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cand_s         <= '0;
            cand_t         <= '0;
            fail_valid     <= 1'b0;
            fail_s         <= '0;
            fail_t         <= '0;
            fail_x         <= '0;
            ic_count       <= '0;
            fail_count     <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        idx            <= '0;
                        ic_count       <= '0;
                        fail_count     <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                        state          <= DRIVE;
                    end
                end
                DRIVE: begin
                    cand_s <= idx[W-1:0];
                    cand_t <= idx[2*W-1:W];
                    state  <= SAMPLE;
                end
                SAMPLE: begin
                    if (ic)
                        ic_count <= ic_count + CNT_W'(1);
                    if (fail) begin
                        fail_count <= fail_count + CNT_W'(1);
                        if (!first_fail_vld) begin
                            first_fail     <= {cand_s, cand_t, cand_x};
                            first_fail_vld <= 1'b1;
                        end
                        fail_s     <= cand_s;
                        fail_t     <= cand_t;
                        fail_x     <= cand_x;
                        fail_valid <= 1'b1;
                        state      <= REPORT;
                    end else if (last) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= DRIVE;
                    end
                end
                REPORT: begin
                    if (fail_ready) begin
                        fail_valid <= 1'b0;
                        if (last) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Self-checking bench for skolem_sweep_checker (W=4).
// Scoreboard of expected failing triples, per-scenario tasks.
module tb_skolem_sweep_checker;

    localparam int W     = 4;
    localparam int CNT_W = 2 * W + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic [W-1:0]     cand_s;
    logic [W-1:0]     cand_t;
    logic [W-1:0]     cand_x;
    logic             fail_valid;
    logic             fail_ready;
    logic [W-1:0]     fail_s;
    logic [W-1:0]     fail_t;
    logic [W-1:0]     fail_x;
    logic [CNT_W-1:0] ic_count;
    logic [CNT_W-1:0] fail_count;
    logic [3*W-1:0]   first_fail;
    logic             first_fail_vld;

    int checks = 0;
    int errors = 0;
    int cand_mode = 0;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] t;
        logic [W-1:0] x;
    } trip_t;

    trip_t q[$];

    skolem_sweep_checker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .cand_s         (cand_s),
        .cand_t         (cand_t),
        .cand_x         (cand_x),
        .fail_valid     (fail_valid),
        .fail_ready     (fail_ready),
        .fail_s         (fail_s),
        .fail_t         (fail_t),
        .fail_x         (fail_x),
        .ic_count       (ic_count),
        .fail_count     (fail_count),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    function automatic int sra_m(input int v, input int s);
        if (s >= W)
            return (v < 0) ? -1 : 0;
        return v >>> s;
    endfunction

    function automatic logic [W-1:0] ref_x(input logic [W-1:0] s,
                                           input logic [W-1:0] t);
        for (int v = -(1 << (W-1)); v < (1 << (W-1)); v++)
            if (sra_m(v, int'(s)) < sx(t))
                return W'(v);
        return '0;
    endfunction

    always_comb begin
        cand_x = '0;
        if (cand_mode == 0)
            cand_x = ref_x(cand_s, cand_t);
    end

    // Runs one sweep; returns at the negedge where done is seen, or
    // right after asserting rst_n when abort_at is reached.
    task automatic run_sweep(
        input  int               mode,
        input  int               stall,
        input  bit               spam,
        input  int               abort_at,
        output int               lat,
        output logic [CNT_W-1:0] icc,
        output logic [CNT_W-1:0] fcc,
        output logic             ffv,
        output logic [3*W-1:0]   ff,
        output int               hs
    );
        int  k;
        int  stall_left;
        bit  done_seen;
        trip_t e;
        cand_mode = mode;
        q.delete();
        for (int i = 0; i < (1 << (2*W)); i++) begin
            logic [W-1:0] s;
            logic [W-1:0] t;
            logic [W-1:0] x;
            s = W'(i);
            t = W'(i >> W);
            x = (mode == 0) ? ref_x(s, t) : '0;
            if (sra_m(-(1 << (W-1)), int'(s)) < sx(t) &&
                !(sra_m(sx(x), int'(s)) < sx(t))) begin
                e.s = s; e.t = t; e.x = x;
                q.push_back(e);
            end
        end
        lat = 0; hs = 0; k = 0;
        done_seen = 0;
        stall_left = stall;
        start = 1'b1;
        fail_ready = 1'b1;
        @(posedge clk);
        while (!done_seen && k < 3000) begin
            @(negedge clk);
            start = (spam && busy && (k % 7 == 3)) ? 1'b1 : 1'b0;
            if (abort_at > 0 && k == abort_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                return;
            end
            if (k == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_rise: got %b want 1", busy);
                end
            end
            if (done === 1'b1) begin
                done_seen = 1;
                lat = k;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_fall: got %b want 0", busy);
                end
            end else begin
                if (fail_valid && stall_left > 0) begin
                    fail_ready = 1'b0;
                    stall_left--;
                    checks++;
                    if ({fail_s, fail_t, fail_x} !== '0) begin
                        errors++;
                        $display("FAIL stall_hold: got %h want 000",
                                 {fail_s, fail_t, fail_x});
                    end
                end else begin
                    fail_ready = 1'b1;
                end
                if (fail_valid === 1'b1 && fail_ready) begin
                    hs++;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_fail: got %h want none",
                                 {fail_s, fail_t, fail_x});
                    end else begin
                        e = q.pop_front();
                        if ({fail_s, fail_t, fail_x} !== {e.s, e.t, e.x}) begin
                            errors++;
                            $display("FAIL triple: got %h want %h",
                                     {fail_s, fail_t, fail_x},
                                     {e.s, e.t, e.x});
                        end
                    end
                    if (mode == 1) begin
                        checks++;
                        if (sx(fail_t) > 0) begin
                            errors++;
                            $display("FAIL t_sign: got %0d want <=0",
                                     sx(fail_t));
                        end
                    end
                end
            end
            if (!done_seen) begin
                @(posedge clk);
                k++;
            end
        end
        fail_ready = 1'b1;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL timeout: got no done want done");
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_fails: got %0d left want 0", q.size());
        end
        icc = ic_count;
        fcc = fail_count;
        ffv = first_fail_vld;
        ff  = first_fail;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        fail_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, fail_valid, cand_s, cand_t, fail_s, fail_t,
             fail_x, ic_count, fail_count, first_fail,
             first_fail_vld} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b ic=%0d fc=%0d",
                     busy, done, ic_count, fail_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_correct();
        int lat, hs;
        logic [CNT_W-1:0] icc, fcc;
        logic ffv;
        logic [3*W-1:0] ff;
        run_sweep(0, 0, 0, 0, lat, icc, fcc, ffv, ff, hs);
        checks++;
        if (icc !== 139) begin
            errors++;
            $display("FAIL correct_ic: got %0d want 139", icc);
        end
        checks++;
        if (fcc !== 0 || hs != 0) begin
            errors++;
            $display("FAIL correct_fc: got %0d/%0d want 0", fcc, hs);
        end
        checks++;
        if (ffv !== 1'b0) begin
            errors++;
            $display("FAIL correct_ffv: got %b want 0", ffv);
        end
        checks++;
        if (lat != 513) begin
            errors++;
            $display("FAIL correct_lat: got %0d want 513", lat);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ic_count !== 139 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_done: got ic=%0d busy=%b done=%b",
                     ic_count, busy, done);
        end
    endtask

    task automatic test_stuck_zero();
        int lat, hs;
        logic [CNT_W-1:0] icc, fcc;
        logic ffv;
        logic [3*W-1:0] ff;
        run_sweep(1, 0, 0, 0, lat, icc, fcc, ffv, ff, hs);
        checks++;
        if (icc !== 139 || fcc !== 27) begin
            errors++;
            $display("FAIL stuck_counts: got ic=%0d fc=%0d want 139/27",
                     icc, fcc);
        end
        checks++;
        if (hs != 27) begin
            errors++;
            $display("FAIL stuck_hs: got %0d want 27", hs);
        end
        checks++;
        if (ffv !== 1'b1 || ff !== '0) begin
            errors++;
            $display("FAIL stuck_first: got %b/%h want 1/000", ffv, ff);
        end
        checks++;
        if (lat != 540) begin
            errors++;
            $display("FAIL stuck_lat: got %0d want 540", lat);
        end
    endtask

    task automatic test_stall();
        int lat, hs;
        logic [CNT_W-1:0] icc, fcc;
        logic ffv;
        logic [3*W-1:0] ff;
        run_sweep(1, 10, 0, 0, lat, icc, fcc, ffv, ff, hs);
        checks++;
        if (icc !== 139 || fcc !== 27 || hs != 27) begin
            errors++;
            $display("FAIL stall_counts: got ic=%0d fc=%0d hs=%0d",
                     icc, fcc, hs);
        end
        checks++;
        if (lat != 550) begin
            errors++;
            $display("FAIL stall_lat: got %0d want 550", lat);
        end
    endtask

    task automatic test_abort();
        int lat, hs;
        logic [CNT_W-1:0] icc, fcc;
        logic ffv;
        logic [3*W-1:0] ff;
        bit saw_done;
        run_sweep(1, 0, 0, 100, lat, icc, fcc, ffv, ff, hs);
        @(negedge clk);
        checks++;
        if ({busy, done, fail_valid, cand_s, cand_t, fail_s, fail_t,
             fail_x, ic_count, fail_count, first_fail,
             first_fail_vld} !== '0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b fv=%b ic=%0d fc=%0d",
                     busy, fail_valid, ic_count, fail_count);
        end
        rst_n = 1'b1;
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_idle: got activity want idle");
        end
        run_sweep(0, 0, 0, 0, lat, icc, fcc, ffv, ff, hs);
        checks++;
        if (icc !== 139 || fcc !== 0 || lat != 513) begin
            errors++;
            $display("FAIL abort_rerun: got ic=%0d fc=%0d lat=%0d",
                     icc, fcc, lat);
        end
    endtask

    task automatic test_start_spam();
        int lat, hs;
        logic [CNT_W-1:0] icc, fcc;
        logic ffv;
        logic [3*W-1:0] ff;
        run_sweep(1, 0, 1, 0, lat, icc, fcc, ffv, ff, hs);
        checks++;
        if (icc !== 139 || fcc !== 27 || lat != 540) begin
            errors++;
            $display("FAIL spam: got ic=%0d fc=%0d lat=%0d",
                     icc, fcc, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, hs1, lat2, hs2;
        logic [CNT_W-1:0] icc1, fcc1, icc2, fcc2;
        logic ffv1, ffv2;
        logic [3*W-1:0] ff1, ff2;
        run_sweep(1, 0, 0, 0, lat1, icc1, fcc1, ffv1, ff1, hs1);
        run_sweep(1, 0, 0, 0, lat2, icc2, fcc2, ffv2, ff2, hs2);
        checks++;
        if (icc2 !== 139 || fcc2 !== 27 || hs2 != 27 || lat2 != 540) begin
            errors++;
            $display("FAIL b2b_second: got ic=%0d fc=%0d hs=%0d lat=%0d",
                     icc2, fcc2, hs2, lat2);
        end
        checks++;
        if (ffv2 !== 1'b1 || ff2 !== '0) begin
            errors++;
            $display("FAIL b2b_first: got %b/%h want 1/000", ffv2, ff2);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_correct();
        test_stuck_zero();
        test_stall();
        test_abort();
        test_start_spam();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/skolem_sweep_checker.md
# skolem_sweep_checker

Sequential verification controller for a W-bit Skolem witness function of the bvslt/bvashr invertibility problem. The function finds x such that (x >>a s) <s t. The block sweeps every (s, t) pair, drives the candidate combinational function, and reads back the witness x. For each pair it checks the witness against the invertibility condition, accumulates statistics, and streams failing triples over a valid/ready port. It sits beside the generated Skolem netlists as the on-chip or in-bench self-checker.

## Interface
- W, 4: operand width. Sweep size is 2^(2W) pairs.
- CNT_W, 2*W+1: width of statistic counters.

- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  pulse; begins a sweep when idle
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the sweep completes
- cand_s  out  W  s operand to the candidate function (registered)
- cand_t  out  W  t operand to the candidate function (registered)
- cand_x  in  W  witness returned combinationally by the candidate
- fail_valid  out  1  failing triple available
- fail_ready  in  1  consumer accepts the triple
- fail_s, fail_t, fail_x  out  W each  failing triple
- ic_count  out  CNT_W  number of pairs where the invertibility condition holds
- fail_count  out  CNT_W  number of pairs where the condition holds but x fails
- first_fail  out  3W  {s,t,x} of the first failure; first_fail_vld  out  1

## Operation
- Pair index idx is 2W bits: s = idx[W-1:0], t = idx[2W-1:W]. s is the fast-varying field. The sweep starts at idx 0 and ends at idx 2^(2W)-1.
- Invertibility condition: ic = (MIN >>a s) <s t, where MIN = {1'b1, (W-1)'b0}.
  - Shift amounts ≥ W saturate to sign fill, so MIN >>a s = all-ones.
- Satisfaction: sat = (cand_x >>a s) <s t, using the same shift and signed-compare rules.
- A pair fails iff ic && !sat. A pair with !ic is never counted as a failure.
- FSM states:
  - IDLE: on start go to DRIVE. This clears counters, first_fail_vld and idx.
  - DRIVE: register cand_s/cand_t from idx, then go to SAMPLE.
  - SAMPLE: evaluate ic and sat on cand_x. Update ic_count.
    - On failure: increment fail_count, capture first_fail if it is not yet valid, load fail_* and go to REPORT.
    - Otherwise, if idx is last go to DONE; else increment idx and go to DRIVE.
  - REPORT: hold fail_valid. On fail_valid && fail_ready, advance exactly as SAMPLE does on a pass.
  - DONE: pulse done for one cycle, then go to IDLE.
- start is ignored unless in IDLE.
- Counters and first_fail hold their values after done until the next start.
- Counters do not wrap, because CNT_W covers 2^(2W).

## Timing
- Reset (rst_n low at a clk edge) puts the block in IDLE. All outputs are 0: busy, done, fail_valid, cand_s, cand_t, fail_*, counters, first_fail, first_fail_vld. A reset mid-sweep or mid-REPORT aborts immediately and emits no done.
- busy rises the cycle after start is sampled in IDLE and falls in the same cycle done is high.
- Each pair takes 2 cycles (DRIVE, SAMPLE), plus 1 + stall cycles per failure in REPORT.
- With zero failures and fail_ready tied high, done occurs 2·2^(2W)+1 cycles after start is sampled. For W=4 that is 513 cycles.
- cand_x is sampled in SAMPLE, one full cycle after cand_s/cand_t change. The candidate path has one cycle to settle.
- fail_s/t/x stay stable while fail_valid is high and fail_ready is low. fail_valid drops the cycle after the handshake.
- fail_ready has no effect outside REPORT.

## Structure
- Shared package skolem_chk_pkg holds:
  - the state enum;
  - a function sra_sat(x, s), an arithmetic right shift with saturation for s ≥ W;
  - a function slt(a, b), a signed less-than.
- One sub-module, skolem_pair_eval: combinational ic/sat/fail evaluation from (s, t, x). It is reusable by the other predicate checkers (bvult, bvshl variants).
- The candidate function is connected externally. The checker contains no Skolem logic.

## Test plan
- Correct candidate (a reference model returning a valid witness), W=4, fail_ready=1 → ic_count=139, fail_count=0, first_fail_vld=0, done at cycle 513 after start.
- Stuck-zero candidate (cand_x=0) → fail_count=27, ic_count=139.
  - first_fail={s=0,t=0,x=0}.
  - Exactly 27 fail handshakes, each with a t ≤ 0 value.
- Stuck-zero candidate with fail_ready low for 10 cycles on the first failure → fail_* hold {0,0,0} for all 10 cycles. Final counts are unchanged and done is delayed by exactly 10 cycles.
- Reset asserted at cycle 100 of a sweep → the next cycle shows all outputs 0 and the FSM in IDLE with no done pulse. A new start gives full correct results.
- start pulsed repeatedly while busy → ignored. A single sweep completes with counts identical to a single-start run.
- Back-to-back sweeps (start the cycle after done) → the counters clear and the second sweep's results match the first.
